// File: rtl/pipe_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// pipe_if_fetch_queue
//
// Instruction-fetch stage for the dynamic pipeline CPU. It owns the fetch PC,
// requests instructions from memory over a req/ack handshake, and buffers
// the returned {pc, inst} pairs in a DEPTH-entry circular queue. An ID-stage
// stall therefore does not stall instruction memory until the queue fills.
// A redirect (branch, jr, jump or exception vector) flushes the queue and
// reloads the fetch PC in a single cycle.
//
// Parameters
//   WIDTH     address / PC width in bits
//   DEPTH     fetch queue entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous active-high reset
//   pcsource    redirect select: 000 seq, 001 bpc, 010 rpc, 011 jpc,
//               100 cpc, 101..111 behave as 000
//   bpc/rpc/jpc/cpc  redirect targets (low two bits ignored)
//   imem_req    fetch request valid
//   imem_addr   fetch address (the current fetch PC)
//   imem_ack    memory returns imem_rdata this cycle
//   imem_rdata  fetched instruction
//   id_ready    ID accepts the queue head this cycle
//   if_valid    queue head valid
//   inst        head instruction (0 when empty)
//   pc          head instruction address (0 when empty)
//   pc4         pc + 4 modulo 2^WIDTH (0 when empty)
// ---------------------------------------------------------------------------
module pipe_if_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       pcsource,
    input  logic [WIDTH-1:0] bpc,
    input  logic [WIDTH-1:0] rpc,
    input  logic [WIDTH-1:0] jpc,
    input  logic [WIDTH-1:0] cpc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             id_ready,
    output logic             if_valid,
    output logic [31:0]      inst,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Redirect select encodings.
    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_BRANCH = 3'b001;
    localparam logic [2:0] SEL_REG    = 3'b010;
    localparam logic [2:0] SEL_JUMP   = 3'b011;
    localparam logic [2:0] SEL_EXC    = 3'b100;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] fetch_pc;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] q_pc   [DEPTH];
    logic [31:0]      q_inst [DEPTH];

    // -----------------------------------------------------------------------
    // Redirect target selection
    // -----------------------------------------------------------------------
    logic             redirect;
    logic [WIDTH-1:0] target_raw;
    logic [WIDTH-1:0] target;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        redirect   = 1'b0;
        target_raw = '0;
        case (pcsource)
            SEL_BRANCH: begin redirect = 1'b1; target_raw = bpc; end
            SEL_REG:    begin redirect = 1'b1; target_raw = rpc; end
            SEL_JUMP:   begin redirect = 1'b1; target_raw = jpc; end
            SEL_EXC:    begin redirect = 1'b1; target_raw = cpc; end
            SEL_SEQ:    ;
            default:    ;  // 101..111 fall back to sequential fetch
        endcase
    end

    // Instructions are word aligned; the low two bits of a target are dropped.
    assign target = {target_raw[WIDTH-1:2], 2'b00};

    // -----------------------------------------------------------------------
    // Handshake and queue control
    // -----------------------------------------------------------------------
    logic full;
    logic push;
    logic pop;

    assign full = (count == CNT_FULL);

    // A full queue blocks the request even if ID pops this cycle; the
    // request comes back the cycle after the pop lands.
    assign imem_req  = !redirect && !full;
    assign imem_addr = fetch_pc;

    // imem_ack is only meaningful while a request is outstanding.
    assign push = imem_req && imem_ack;

    // A redirect squashes the head, so nothing is popped that cycle.
    assign pop  = if_valid && id_ready && !redirect;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + PC_STEP;
                wr_ptr   <= wr_ptr + 1'b1;  // wraps modulo DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;  // idle, or push and pop together
            endcase
        end
    end

    // NOTE: the queue storage is deliberately not reset; count gates every
    // read, so stale entries are never observed and the array stays plain RAM.
    always_ff @(posedge clock) begin
        if (push && !redirect && !reset) begin
            q_pc[wr_ptr]   <= fetch_pc;
            q_inst[wr_ptr] <= imem_rdata;
        end
    end

    // -----------------------------------------------------------------------
    // Head presentation: an empty queue shows an all-zero bubble (a nop).
    // There is no bypass from imem_rdata, so an ack reaches ID one cycle later.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] head_pc;
    logic [31:0]      head_inst;

    assign head_pc   = q_pc[rd_ptr];
    assign head_inst = q_inst[rd_ptr];

    assign if_valid = (count != '0);
    assign inst     = if_valid ? head_inst : 32'h0;
    assign pc       = if_valid ? head_pc : '0;
    assign pc4      = if_valid ? (head_pc + PC_STEP) : '0;

endmodule

// File: tb/tb_pipe_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_fetch_queue
//
// Directed bench for pipe_if_fetch_queue. Instance u_dut runs with
// RESET_PC = 0; instance u_wrap starts at 32'hFFFF_FFF8 to exercise address
// wrap. Memory returns addr ^ 32'hA5A5_0000 so every instruction is
// predictable from its address. Inputs change 1 ns after the rising edge and
// outputs are checked there, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_if_fetch_queue;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus / observation for u_dut
    logic        reset, imem_ack, id_ready;
    logic [2:0]  pcsource;
    logic [31:0] bpc, rpc, jpc, cpc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, imem_rdata, inst, pc, pc4;

    // Stimulus / observation for u_wrap
    logic        reset_w, ack_w, ready_w;
    logic        req_w, valid_w;
    logic [31:0] addr_w, rdata_w, inst_w, pc_w, pc4_w;

    assign imem_rdata = imem_addr ^ XOR_KEY;
    assign rdata_w    = addr_w ^ XOR_KEY;

    pipe_if_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clock(clock), .reset(reset), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .cpc(cpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_ready(id_ready), .if_valid(if_valid),
        .inst(inst), .pc(pc), .pc4(pc4)
    );

    pipe_if_fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clock(clock), .reset(reset_w), .pcsource(3'b000),
        .bpc(32'h0), .rpc(32'h0), .jpc(32'h0), .cpc(32'h0),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w),
        .id_ready(ready_w), .if_valid(valid_w),
        .inst(inst_w), .pc(pc_w), .pc4(pc4_w)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0; pcsource = 3'b000;
        bpc = '0; rpc = '0; jpc = '0; cpc = '0;
        reset_w = 1'b1; ack_w = 1'b1; ready_w = 1'b1;
        step();

        // ---- Reset state ----
        reset = 1'b0;
        #1;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_inst",  inst, 32'h0);
        check("rst_pc",    pc,   32'h0);
        check("rst_pc4",   pc4,  32'h0);
        check("rst_req",   32'(imem_req), 32'd1);
        check("rst_addr",  imem_addr, 32'h0);

        // ---- Streaming: ack and id_ready every cycle ----
        imem_ack = 1'b1; id_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("seq_addr",  imem_addr, 32'(4 * k));
            check("seq_valid", 32'(if_valid), 32'd1);
            check("seq_pc",    pc,   32'(4 * (k - 1)));
            check("seq_inst",  inst, 32'(4 * (k - 1)) ^ XOR_KEY);
            check("seq_pc4",   pc4,  32'(4 * k));
        end

        // ---- Fill to DEPTH with ID stalled, then drain ----
        reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
        step();
        reset = 1'b0; imem_ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("fill_addr", imem_addr, 32'(4 * k));
        end
        check("full_req", 32'(imem_req), 32'd0);
        step(); step();
        check("full_hold_addr", imem_addr, 32'd16);
        check("full_hold_req",  32'(imem_req), 32'd0);
        imem_ack = 1'b0; id_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("drain_pc",   pc,   32'(4 * k));
            check("drain_inst", inst, 32'(4 * k) ^ XOR_KEY);
            step();
            if (k == 0) check("req_resume", 32'(imem_req), 32'd1);
        end
        check("drained_valid", 32'(if_valid), 32'd0);
        check("drained_inst",  inst, 32'h0);
        check("drained_addr",  imem_addr, 32'd16);

        // ---- Jump redirect with two entries queued ----
        reset = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b1; id_ready = 1'b0;
        step(); step();
        check("pre_jmp_addr", imem_addr, 32'd8);
        pcsource = 3'b011; jpc = 32'h0000_0403;
        #1;
        check("jmp_req_low", 32'(imem_req), 32'd0);
        step();
        pcsource = 3'b000; imem_ack = 1'b0;
        #1;
        check("jmp_valid", 32'(if_valid), 32'd0);
        check("jmp_addr",  imem_addr, 32'h0000_0400);
        check("jmp_req",   32'(imem_req), 32'd1);
        imem_ack = 1'b1; id_ready = 1'b1;
        step();
        check("jmp_head_pc",   pc,   32'h0000_0400);
        check("jmp_head_inst", inst, 32'h0000_0400 ^ XOR_KEY);

        // ---- Exception redirect with ack and id_ready both high ----
        pcsource = 3'b100; cpc = 32'h8000_0180;
        step();
        pcsource = 3'b000;
        #1;
        check("exc_valid", 32'(if_valid), 32'd0);
        check("exc_addr",  imem_addr, 32'h8000_0180);
        step();
        check("exc_head_pc", pc, 32'h8000_0180);

        // ---- Reserved select 101 behaves as sequential ----
        pcsource = 3'b101;
        #1;
        check("sel101_req", 32'(imem_req), 32'd1);
        step();
        pcsource = 3'b000;
        check("sel101_pc",   pc,        32'h8000_0184);
        check("sel101_addr", imem_addr, 32'h8000_0188);

        // ---- Address wrap on u_wrap ----
        reset_w = 1'b0;
        #1;
        check("wrap_rst_addr",  addr_w, 32'hFFFF_FFF8);
        check("wrap_rst_valid", 32'(valid_w), 32'd0);
        step();
        check("wrap_pc0",   pc_w,   32'hFFFF_FFF8);
        check("wrap_addr0", addr_w, 32'hFFFF_FFFC);
        step();
        check("wrap_pc1",   pc_w,   32'hFFFF_FFFC);
        check("wrap_pc4_1", pc4_w,  32'h0000_0000);
        check("wrap_addr1", addr_w, 32'h0000_0000);
        step();
        check("wrap_pc2",   pc_w,   32'h0000_0000);
        check("wrap_pc4_2", pc4_w,  32'h0000_0004);

        // ---- Slow memory, then reset in the middle of a wait ----
        reset = 1'b1; imem_ack = 1'b0; id_ready = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            imem_ack = 1'b0; step();
            imem_ack = 1'b0; step();
            imem_ack = 1'b1; step();
            imem_ack = 1'b0;
            check("slow_valid", 32'(if_valid), 32'd1);
            check("slow_pc",    pc, 32'(4 * r));
        end
        step();
        check("slow_empty", 32'(if_valid), 32'd0);
        reset = 1'b1; imem_ack = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_inst",  inst, 32'h0);
        check("mid_rst_pc",    pc,   32'h0);
        check("mid_rst_pc4",   pc4,  32'h0);
        check("mid_rst_req",   32'(imem_req), 32'd1);
        check("mid_rst_addr",  imem_addr, 32'h0);
        step();
        check("stale_ack_valid", 32'(if_valid), 32'd0);
        check("stale_ack_addr",  imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
